pipeline_ctrl: RTL

Central control unit for the five-stage pipeline. It drives the write enables of the PC and the four stage registers (FD, DE, EM, MW) and the bubble-insert selects that make the top level load zeros (a NOP) into a stage register. It resolves load-use hazards, taken-branch flushes, instruction- and data-memory wait states, and a debug halt/single-step mode. It also counts stall and flush events.

---
 rtl/pipeline_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline control: stage write enables, bubble selects, hazard/flush/wait-state resolution,
// debug halt/single-step, memory-timeout lockup and saturating stall/flush event counters.
module pipeline_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             em_mem_read,
  input  logic             em_mem_write,
  input  logic             em_branch_taken,
  input  logic             de_mem_read,
  input  logic [4:0]       de_dst_reg,
  input  logic [4:0]       fd_rs,
  input  logic [4:0]       fd_rt,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             pc_wren,
  output logic             fd_wren,
  output logic             de_wren,
  output logic             em_wren,
  output logic             mw_wren,
  output logic             fd_bubble,
  output logic             de_bubble,
  output logic             em_bubble,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {RUN, HALT, STEP, ERR} state_t;

  state_t           state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic active, mem_op, dstall, flush, luse, istall, mstall;

  assign active = reset_n && (state_q == RUN || state_q == STEP);
  assign mem_op = em_mem_read | em_mem_write;
  assign dstall = mem_op & ~dmem_ack;
  assign flush  = em_branch_taken;
  assign luse   = de_mem_read && (de_dst_reg != 5'd0) &&
                  (de_dst_reg == fd_rs || de_dst_reg == fd_rt);
  assign istall = ~imem_ack;
  // A pending fetch is dropped by a flush and irrelevant under a load-use hold.
  assign mstall = dstall | (istall & ~flush & ~luse);

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    pc_wren     = 1'b0;
    fd_wren     = 1'b0;
    de_wren     = 1'b0;
    em_wren     = 1'b0;
    mw_wren     = 1'b0;
    fd_bubble   = 1'b0;
    de_bubble   = 1'b0;
    em_bubble   = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (active) begin
      imem_req = 1'b1;
      dmem_req = mem_op;
      if (dstall) begin
        pc_wren = 1'b0;
      end else if (flush) begin
        {pc_wren, fd_wren, de_wren, em_wren, mw_wren} = 5'b11111;
        {fd_bubble, de_bubble, em_bubble}             = 3'b111;
      end else if (luse) begin
        {de_wren, em_wren, mw_wren} = 3'b111;
        de_bubble                   = 1'b1;
      end else if (istall) begin
        {fd_wren, de_wren, em_wren, mw_wren} = 4'b1111;
        fd_bubble                            = 1'b1;
      end else begin
        {pc_wren, fd_wren, de_wren, em_wren, mw_wren} = 5'b11111;
      end

      if (mstall) wait_cnt_d = wait_cnt_q + WW'(1);
      if ((dstall || (!flush && (luse || istall))) && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && !dstall && flush_cnt_q != '1)
        flush_cnt_d = flush_cnt_q + 1'b1;
    end

    case (state_q)
      RUN:  if (halt_req) state_d = HALT;
      HALT: if (step_req) state_d = STEP;
            else if (!halt_req) state_d = RUN;
      STEP: if (!dstall) state_d = HALT;
      ERR:  state_d = ERR;
    endcase
    if (active && mstall && wait_cnt_q == WAIT_LAST) state_d = ERR;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted    = (state_q == HALT);
  assign bus_error = (state_q == ERR);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
